// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetch stage.
// JAL_PREDICT_EN enables static prediction of JAL targets via predict_pc().
package inst_fetcher_pkg;

  localparam logic [6:0] OpJal = 7'b1101111;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] word);
    return {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
  endfunction

  // Target of the next fetch once `word` has been fetched from `pc`.
  function automatic logic [31:0] predict_pc(input logic [31:0] pc, input logic [31:0] word);
    if (word[6:0] == OpJal) begin
      return pc + imm_j(word);
    end
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-side memory bus: single outstanding request, ended by mem_ready_in.
interface inst_fetcher_if;

  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ready_in;
  logic [31:0] mem_data_in;

  modport master (
    output mem_req_out,
    output mem_addr_out,
    input  mem_ready_in,
    input  mem_data_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_addr_out,
    output mem_ready_in,
    output mem_data_in
  );

endinterface

// File: rtl/inst_fetcher_queue.sv
// Instruction queue: circular FIFO of {inst, pc} with synchronous clear.
// Depth must be a power of two so the pointers wrap naturally.
module inst_fetcher_queue
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t         mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [$clog2(Depth):0] count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (pop_i && !push_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC, single-outstanding memory fetch FSM and decoder-facing queue.
// Define JAL_PREDICT_EN to follow JAL targets at fetch time instead of waiting for a flush.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic [31:0]          flush_pc_in,
  input  logic                 stall_in,
  inst_fetcher_if.master       mem_bus,
  output logic                 inst_req_out,
  output logic [31:0]          inst_out,
  output logic [31:0]          pc_out
);

  localparam int unsigned      CntW     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CntW-1:0]  DepthCnt = CntW'(QUEUE_DEPTH);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic          inst_req_q;
  logic [31:0]   inst_q;
  logic [31:0]   pc_out_q;

  logic [31:0]   next_pc;
  logic          push;
  logic          pop;
  fetch_entry_t  push_data;
  fetch_entry_t  head;
  logic [CntW-1:0] count;

`ifdef JAL_PREDICT_EN
  assign next_pc = predict_pc(pc_q, mem_bus.mem_data_in);
`else
  assign next_pc = pc_q + 32'd4;
`endif

  // Flush wins over both queue operations; the queue is cleared on the same edge.
  assign push      = (state_q == StWait) && mem_bus.mem_ready_in && !flush_in;
  assign pop       = (count != '0) && !stall_in && !flush_in;
  assign push_data = '{inst: mem_bus.mem_data_in, pc: pc_q};

  inst_fetcher_queue #(
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_i     (flush_in),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      inst_req_q <= 1'b0;
      inst_q     <= '0;
      pc_out_q   <= '0;
    end else if (flush_in) begin
      pc_q       <= flush_pc_in;
      inst_req_q <= 1'b0;
      // An unfinished request must still be completed on the bus; its data is dropped later.
      if (mem_req_q && !mem_bus.mem_ready_in) begin
        state_q <= StDiscard;
      end else begin
        state_q   <= StIdle;
        mem_req_q <= 1'b0;
      end
    end else begin
      inst_req_q <= pop;
      if (pop) begin
        inst_q   <= head.inst;
        pc_out_q <= head.pc;
      end
      unique case (state_q)
        StIdle: begin
          if (count < DepthCnt) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (mem_bus.mem_ready_in) begin
            mem_req_q <= 1'b0;
            pc_q      <= next_pc;
            state_q   <= StIdle;
          end
        end
        StDiscard: begin
          if (mem_bus.mem_ready_in) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_bus.mem_req_out  = mem_req_q;
  assign mem_bus.mem_addr_out = mem_addr_q;
  assign inst_req_out         = inst_req_q;
  assign inst_out             = inst_q;
  assign pc_out               = pc_out_q;

endmodule
